ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that drives the combinational instruction ROM (cs_rom / pc_addr / i_out) and buffers fetched words in a small prefetch queue.
- Delivers words to the decode stage through a valid/ready handshake.
- Accepts branch/jump redirects from the pipeline; a redirect flushes the queue and restarts fetch at the target.
- Sits between the PC logic and the IF/ID register.

---
 rtl/ifetch_ctrl.sv | 124 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: drives the combinational ROM and buffers words in a prefetch queue.
// Latency: word fetched in cycle N is presented on if_instr/if_pc in cycle N+1.
// Backpressure: if_ready low fills the queue, then fetch stops (HOLD) until a pop frees a slot.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   fetch_en                    permits new fetches (pops continue regardless)
//   redirect, redirect_pc       flush queue and restart fetch at word-aligned target
//   cs_rom, pc_addr, i_out      ROM chip select, byte address, same-cycle read data
//   if_valid, if_ready          head-of-queue handshake towards decode
//   if_instr, if_pc             head instruction and its address (0 when empty)
//   q_count                     queue occupancy
module ifetch_ctrl #(
  parameter int                  WIDTH_I  = 32,
  parameter int                  DEPTH_Q  = 4,
  parameter logic [WIDTH_I-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_en,
  input  logic                        redirect,
  input  logic [WIDTH_I-1:0]          redirect_pc,
  output logic                        cs_rom,
  output logic [WIDTH_I-1:0]          pc_addr,
  input  logic [WIDTH_I-1:0]          i_out,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [WIDTH_I-1:0]          if_instr,
  output logic [WIDTH_I-1:0]          if_pc,
  output logic [$clog2(DEPTH_Q):0]    q_count
);

  localparam int AW = $clog2(DEPTH_Q);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH_Q);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t              state;
  logic [WIDTH_I-1:0]  fetch_pc;
  logic [WIDTH_I-1:0]  instr_q [DEPTH_Q];
  logic [WIDTH_I-1:0]  pc_q    [DEPTH_Q];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [AW:0]         count_nxt;
  logic                push;
  logic                pop;
  logic                redirect_lsb_unused;

  // Target is always word aligned; the low bits are dropped on purpose.
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Fetch gating uses only registered count so if_ready never reaches cs_rom.
  assign push    = (state == FETCH) && fetch_en && !redirect && (count < FULL);
  assign pop     = (count != '0) && if_ready && !redirect;
  assign cs_rom  = push;
  assign pc_addr = fetch_pc;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (AW+1)'(1);
    else if (!push && pop)
      count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      // Flush wins over any push/pop in the same cycle.
      state    <= fetch_en ? FETCH : IDLE;
      fetch_pc <= {redirect_pc[WIDTH_I-1:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + WIDTH_I'(4);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;

      case (state)
        IDLE: begin
          if (fetch_en)
            state <= FETCH;
        end
        FETCH: begin
          if (!fetch_en)
            state <= IDLE;
          else if (count_nxt == FULL)
            state <= HOLD;
        end
        HOLD: begin
          // Leave as soon as a pop frees a slot, so fetch resumes the next cycle.
          if (count_nxt < FULL)
            state <= fetch_en ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= i_out;
      pc_q[wr_ptr]    <= fetch_pc;
    end
  end

  assign if_valid = (count != '0);
  assign if_instr = if_valid ? instr_q[rd_ptr] : '0;
  assign if_pc    = if_valid ? pc_q[rd_ptr]    : '0;
  assign q_count  = count;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a behavioural ROM.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        cs_rom;
  logic [31:0] pc_addr;
  logic [31:0] i_out;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [2:0]  q_count;

  int errs   = 0;
  int checks = 0;
  int pushes;

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .cs_rom      (cs_rom),
    .pc_addr     (pc_addr),
    .i_out       (i_out),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .q_count     (q_count)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00:  rom_word = 32'h2001_0008;
      32'h04:  rom_word = 32'h3402_000c;
      32'h28:  rom_word = 32'h0800_000d;
      32'h34:  rom_word = 32'had02_000a;
      default: rom_word = 32'hC0DE_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  // Read data is garbage when not selected, so an unselected push is caught.
  assign i_out = cs_rom ? rom_word(pc_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b1;

    // Start-up
    do_reset();
    #1;
    check("rst_cs_rom",   cs_rom,   0);
    check("rst_if_valid", if_valid, 0);
    check("rst_q_count",  q_count,  0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc",    if_pc,    0);
    check("rst_pc_addr",  pc_addr,  0);
    nxt(); #1;
    check("su_cs_rom",    cs_rom,   1);
    check("su_pc_addr0",  pc_addr,  32'h0);
    check("su_valid0",    if_valid, 0);
    nxt(); #1;
    check("su_valid1",    if_valid, 1);
    check("su_instr0",    if_instr, 32'h2001_0008);
    check("su_pc0",       if_pc,    32'h0);
    check("su_pc_addr4",  pc_addr,  32'h4);
    nxt(); #1;
    check("su_instr1",    if_instr, 32'h3402_000c);
    check("su_pc1",       if_pc,    32'h4);
    check("su_pc_addr8",  pc_addr,  32'h8);
    check("su_count",     q_count,  1);

    // Backpressure: fill, hold, then drain in order
    if_ready = 1'b0; fetch_en = 1'b1;
    do_reset();
    pushes = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cs_rom) pushes++;
      nxt();
    end
    #1;
    check("bp_pushes",   pushes,  4);
    check("bp_count",    q_count, 4);
    check("bp_hold_cs",  cs_rom,  0);
    check("bp_pc_frz",   pc_addr, 32'h10);
    if_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("bp_valid", if_valid, 1);
      check("bp_order_pc", if_pc, 32'(4 * k));
      check("bp_order_instr", if_instr, rom_word(32'(4 * k)));
      if (k == 0) check("bp_no_early_fetch", cs_rom, 0);
      if (k == 1) begin
        check("bp_resume_cs", cs_rom, 1);
        check("bp_resume_pc", pc_addr, 32'h10);
      end
      nxt(); #1;
    end
    check("bp_next_pc", if_pc, 32'h10);

    // Redirect with 3 entries queued
    if_ready = 1'b0;
    do_reset();
    repeat (4) nxt();
    #1;
    check("rd_count3", q_count, 3);
    redirect = 1'b1; redirect_pc = 32'h34;
    #1;
    check("rd_cs_off", cs_rom, 0);
    nxt();
    redirect = 1'b0;
    #1;
    check("rd_count0", q_count,  0);
    check("rd_valid0", if_valid, 0);
    check("rd_pc_addr", pc_addr, 32'h34);
    check("rd_cs_on",  cs_rom,   1);
    nxt();
    if_ready = 1'b1;
    #1;
    check("rd_valid1", if_valid, 1);
    check("rd_instr",  if_instr, 32'had02_000a);
    check("rd_pc",     if_pc,    32'h34);

    // Misaligned redirect target
    nxt();
    redirect = 1'b1; redirect_pc = 32'h2A;
    nxt();
    redirect = 1'b0;
    #1;
    check("mis_pc_addr", pc_addr, 32'h28);
    check("mis_valid0",  if_valid, 0);
    nxt(); #1;
    check("mis_instr", if_instr, 32'h0800_000d);
    check("mis_pc",    if_pc,    32'h28);

    // Redirect coincident with pop on a full queue
    if_ready = 1'b0;
    do_reset();
    repeat (7) nxt();
    #1;
    check("rp_full", q_count, 4);
    if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    nxt();
    redirect = 1'b0;
    #1;
    check("rp_count0", q_count,  0);
    check("rp_valid0", if_valid, 0);
    check("rp_instr0", if_instr, 0);
    check("rp_pc_addr", pc_addr, 32'h40);
    nxt(); #1;
    check("rp_pc",    if_pc,    32'h40);
    check("rp_instr", if_instr, rom_word(32'h40));
    check("rp_count1", q_count, 1);
    nxt(); #1;
    check("rp_pc_next", if_pc, 32'h44);

    // fetch_en low mid-stream, then reset during HOLD
    if_ready = 1'b0; fetch_en = 1'b1;
    do_reset();
    repeat (3) nxt();
    fetch_en = 1'b0; if_ready = 1'b1;
    #1;
    check("fe_cs0",   cs_rom,  0);
    check("fe_pc0",   pc_addr, 32'h8);
    check("fe_head0", if_pc,   32'h0);
    nxt(); #1;
    check("fe_cs1",   cs_rom,  0);
    check("fe_pc1",   pc_addr, 32'h8);
    check("fe_head1", if_pc,   32'h4);
    nxt(); #1;
    check("fe_drained", if_valid, 0);
    check("fe_pc2",     pc_addr,  32'h8);
    nxt();
    fetch_en = 1'b1;
    #1;
    check("fe_idle_cs", cs_rom, 0);
    nxt(); #1;
    check("fe_resume_cs", cs_rom,  1);
    check("fe_resume_pc", pc_addr, 32'h8);
    if_ready = 1'b0;
    repeat (6) nxt();
    #1;
    check("hr_full", q_count, 4);
    check("hr_cs",   cs_rom,  0);
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    nxt(); #1;
    check("hr_count",   q_count,  0);
    check("hr_valid",   if_valid, 0);
    check("hr_instr",   if_instr, 0);
    check("hr_if_pc",   if_pc,    0);
    check("hr_pc_addr", pc_addr,  0);
    check("hr_cs_rom",  cs_rom,   0);
    rst = 1'b0; redirect = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
